// File: rtl/irq_service_master.sv
// APB master that re-arms a counter slave, then services its level interrupt
// with a programmable ack delay, repeating until the requested count is reached.
module irq_service_master #(
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0004,
  parameter logic [31:0] CTRL_DATA = 32'h0000_0001,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [7:0]  target_count,
  input  logic [7:0]  service_delay,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        irq,
  output logic        ack_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  serviced_count
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, WAIT_IRQ, DELAY, WAIT_LOW, DONE, ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  target_q;
  logic [7:0]  delay_q;
  logic [7:0]  dly_cnt;
  logic [15:0] tmo_cnt;
  logic [8:0]  target_full;
  logic [8:0]  count_inc;
  logic        start_ok;
  logic        tmo_hit;
  logic        unused_prdata;

  assign unused_prdata = ^PRDATA;
  // A latched target of zero stands for a full run of 256 services.
  assign target_full   = (target_q == 8'd0) ? 9'd256 : {1'b0, target_q};
  assign count_inc     = serviced_count + 9'd1;
  assign start_ok      = start && (state == IDLE || state == ERR);
  assign tmo_hit       = (tmo_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERR: if (start) state_next = SETUP;
      SETUP:     state_next = ACCESS;
      ACCESS:    if (PREADY) state_next = PSLVERR ? ERR : WAIT_IRQ;
      WAIT_IRQ: begin
        if (irq)          state_next = (delay_q == 8'd0) ? WAIT_LOW : DELAY;
        else if (tmo_hit) state_next = ERR;
      end
      DELAY:     if (dly_cnt <= 8'd1) state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (!irq)         state_next = (count_inc == target_full) ? DONE : SETUP;
        else if (tmo_hit) state_next = ERR;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = (state == SETUP) || (state == ACCESS);
    PENABLE = (state == ACCESS);
    PWRITE  = PSEL;
    ack_out = (state == WAIT_LOW);
    busy    = (state != IDLE) && (state != ERR);
    done    = (state == DONE);
    error   = (state == ERR);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      target_q       <= '0;
      delay_q        <= '0;
      dly_cnt        <= '0;
      tmo_cnt        <= '0;
      serviced_count <= '0;
      PADDR          <= '0;
      PWDATA         <= '0;
    end else begin
      if (start_ok) begin
        target_q       <= target_count;
        delay_q        <= service_delay;
        serviced_count <= '0;
      end else if (state == WAIT_LOW && !irq) begin
        serviced_count <= count_inc;
      end
      // Address/data are loaded once per transfer and then held across idle states.
      if (state_next == SETUP) begin
        PADDR  <= CTRL_ADDR;
        PWDATA <= CTRL_DATA;
      end
      if (state == WAIT_IRQ)   dly_cnt <= delay_q;
      else if (state == DELAY) dly_cnt <= dly_cnt - 8'd1;
      // Any state change restarts the wait budget, so each wait state gets a fresh TIMEOUT.
      if (state_next != state)
        tmo_cnt <= '0;
      else if (state == WAIT_IRQ || state == WAIT_LOW)
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_irq_service_master.sv
// Randomized bench for irq_service_master: a behavioural counter-slave drives
// PREADY/PSLVERR/irq while run outcomes are predicted from the service rules.
module tb_irq_service_master;

  localparam logic [31:0] CADDR = 32'h0000_0004;
  localparam logic [31:0] CDATA = 32'h0000_0001;
  localparam int          TMO   = 1000;

  logic        PCLK, PRESETn, start;
  logic [7:0]  target_count, service_delay;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq;
  logic        ack_out, busy, done, error;
  logic [8:0]  serviced_count;

  irq_service_master #(.CTRL_ADDR(CADDR), .CTRL_DATA(CDATA), .TIMEOUT(16'(TMO))) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .target_count(target_count),
    .service_delay(service_delay), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq(irq), .ack_out(ack_out), .busy(busy), .done(done), .error(error),
    .serviced_count(serviced_count)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration (-1 selects a random value per event)
  int cfg_wait = 0, cfg_lat = 4, cfg_drop = 0, cfg_mode = 0, cfg_err_at = -1, cfg_delay = 0;
  bit cfg_glitch = 0;
  // Scoreboard
  int wr_cnt, done_cnt, ack_rises, err_cyc, cpl_cyc, ack_cyc, acc_cycles;
  // Slave internals
  int wait_left = 0, irq_timer = -1, drop_timer = -1, glitch_t = -1, irq_set_cyc = -1;
  logic [31:0] setup_addr = '0, setup_data = '0;
  logic prev_ack = 0, prev_err = 0;

  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        irq = 0; PREADY = 0; PSLVERR = 0;
        irq_timer = -1; drop_timer = -1; glitch_t = -1; irq_set_cyc = -1;
        prev_ack = 0; prev_err = 0;
      end else begin
        if (done) done_cnt++;
        if (error && !prev_err) begin
          err_cyc = cyc; irq = 0; irq_timer = -1; drop_timer = -1; glitch_t = -1;
        end
        if (ack_out && !prev_ack) begin
          ack_rises++; ack_cyc = cyc;
          if (irq_set_cyc >= 0) check("ack_latency", 64'(cyc - irq_set_cyc), 64'(cfg_delay + 1));
          irq_set_cyc = -1;
          if (cfg_mode != 2) drop_timer = (cfg_drop < 0) ? $urandom_range(0, 2) : cfg_drop;
        end
        if (glitch_t == 1) begin irq = 1; glitch_t = -1; end
        else if (glitch_t == 0) begin irq = 0; glitch_t = 1; end
        if (drop_timer == 0) begin irq = 0; drop_timer = -1; end
        else if (drop_timer > 0) drop_timer--;
        if (irq_timer > 0) begin
          irq_timer--;
          if (irq_timer == 0) begin
            irq = 1; irq_set_cyc = cyc; irq_timer = -1;
            if (cfg_glitch && cfg_delay >= 2) glitch_t = 0;
          end
        end
        if (PSEL && !PENABLE) begin
          setup_addr = PADDR; setup_data = PWDATA; acc_cycles = 0;
          wait_left = (cfg_wait < 0) ? $urandom_range(0, 3) : cfg_wait;
          PREADY = 0; PSLVERR = 0;
        end else if (PSEL && PENABLE) begin
          acc_cycles++;
          check("paddr_stable", PADDR, setup_addr);
          check("pwdata_stable", PWDATA, setup_data);
          if (wait_left > 0) begin
            PREADY = 0; PSLVERR = 1'($urandom_range(0, 1)); wait_left--;
          end else begin
            PREADY = 1;
            check("paddr", PADDR, CADDR);
            check("pwdata", PWDATA, CDATA);
            check("pwrite", PWRITE, 1);
            PSLVERR = (wr_cnt == cfg_err_at);
            wr_cnt++; cpl_cyc = cyc;
            if (!PSLVERR && cfg_mode != 1) irq_timer = (cfg_lat < 0) ? $urandom_range(1, 6) : cfg_lat;
          end
        end else begin
          PREADY = 0; PSLVERR = 0;
        end
        prev_ack = ack_out; prev_err = error;
      end
    end
  end

  task automatic tick();
    @(negedge PCLK); #1;
  endtask

  task automatic clear_sb();
    wr_cnt = 0; done_cnt = 0; ack_rises = 0; err_cyc = -1; cpl_cyc = -1; ack_cyc = -1;
  endtask

  // mode: 0 normal slave, 1 irq never rises, 2 irq stuck high after rising
  task automatic run(input int tgt, input int dly, input int err_at, input int mode, input bit poke);
    int n, t_full, exp_wr, exp_srv;
    bit exp_err;
    clear_sb();
    cfg_delay = dly; cfg_err_at = err_at; cfg_mode = mode;
    start = 1; target_count = 8'(tgt); service_delay = 8'(dly);
    tick();
    start = 0; target_count = 8'($urandom); service_delay = 8'($urandom);
    check("error_cleared", error, 0);
    check("busy_run", busy, 1);
    n = 0;
    while (done_cnt == 0 && err_cyc < 0 && n < 20000) begin
      start = (poke && n == 3);
      tick(); n++;
    end
    start = 0;
    check("run_bounded", (n < 20000), 1);
    tick();
    t_full = (tgt == 0) ? 256 : tgt;
    if (mode == 1) begin
      exp_wr = 1; exp_srv = 0; exp_err = 1;
      check("tmo_wait_irq", 64'(err_cyc - cpl_cyc), 64'(TMO + 1));
    end else if (mode == 2) begin
      exp_wr = 1; exp_srv = 0; exp_err = 1;
      check("tmo_wait_low", 64'(err_cyc - ack_cyc), 64'(TMO));
    end else if (err_at >= 0 && err_at < t_full) begin
      exp_wr = err_at + 1; exp_srv = err_at; exp_err = 1;
    end else begin
      exp_wr = t_full; exp_srv = t_full; exp_err = 0;
    end
    check("writes", 64'(wr_cnt), 64'(exp_wr));
    check("serviced", serviced_count, 64'(exp_srv));
    check("acks", 64'(ack_rises), 64'(mode == 2 ? 1 : exp_srv));
    check("done_pulses", 64'(done_cnt), 64'(exp_err ? 0 : 1));
    check("error_flag", error, 64'(exp_err));
    check("busy_end", busy, 0);
    check("ack_end", ack_out, 0);
    check("psel_end", PSEL, 0);
  endtask

  task automatic reset_mid_run();
    int n;
    clear_sb();
    cfg_wait = 0; cfg_lat = 3; cfg_drop = 2; cfg_mode = 0; cfg_err_at = -1; cfg_delay = 2;
    start = 1; target_count = 8'd4; service_delay = 8'd2;
    tick();
    start = 0;
    n = 0;
    while (!(ack_rises == 2 && ack_out) && n < 500) begin tick(); n++; end
    check("reached_service2", (n < 500), 1);
    PRESETn = 0;
    #1;
    check("rst_ack", ack_out, 0);
    check("rst_psel", PSEL, 0);
    check("rst_busy", busy, 0);
    check("rst_serviced", serviced_count, 0);
    tick(); tick();
    PRESETn = 1;
    done_cnt = 0;
    repeat (10) tick();
    check("rst_no_resume", busy, 0);
    check("rst_no_done", 64'(done_cnt), 0);
    check("rst_no_writes", PSEL, 0);
  endtask

  initial begin
    int tgt, dly, ea;
    PRESETn = 0; start = 0; target_count = 0; service_delay = 0;
    PRDATA = 32'hDEAD_BEEF; PREADY = 0; PSLVERR = 0; irq = 0;
    clear_sb(); acc_cycles = 0;
    tick(); tick();
    check("reset_psel", {PSEL, PENABLE, PWRITE}, 0);
    check("reset_paddr", PADDR, 0);
    check("reset_pwdata", PWDATA, 0);
    check("reset_flags", {ack_out, busy, done, error}, 0);
    check("reset_count", serviced_count, 0);
    PRESETn = 1;
    tick();

    cfg_wait = 0; cfg_lat = 4; cfg_drop = 0; cfg_glitch = 0;
    run(5, 3, -1, 0, 0);
    cfg_wait = 2;
    run(1, 1, -1, 0, 0);
    check("access_cycles", 64'(acc_cycles), 3);
    cfg_wait = 0;
    run(3, 2, 0, 0, 0);
    cfg_lat = 2; cfg_drop = 1;
    run(1, 0, -1, 0, 0);
    run(1, 2, -1, 1, 0);
    run(2, 1, -1, 2, 0);
    cfg_glitch = 1; cfg_lat = 3; cfg_drop = 0;
    run(3, 4, -1, 0, 1);

    cfg_wait = -1; cfg_lat = -1; cfg_drop = -1;
    repeat (14) begin
      cfg_glitch = 1'($urandom_range(0, 1));
      tgt = $urandom_range(1, 8);
      dly = $urandom_range(0, 6);
      ea  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tgt + 1) : -1;
      run(tgt, dly, ea, 0, (ea < 0));
    end
    cfg_glitch = 0;
    run(0, 1, -1, 0, 1);

    reset_mid_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
